// File: rtl/iter_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes.
// Works on operand magnitudes and fixes up the result sign on the final step.
module iter_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   m_reg, hi_reg, lo_reg, result_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               accept, special, last_step, div_by_zero, div_ovf;
  logic               signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, special_result;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo, div_val, final_result;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept   = start_valid && (state_reg == IDLE) && !kill;
  assign signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sign_a   = signed_a & operand_a[WIDTH-1];
  assign sign_b   = signed_b & operand_b[WIDTH-1];
  assign mag_a    = sign_a ? -operand_a : operand_a;
  assign mag_b    = sign_b ? -operand_b : operand_b;

  // Divide corner cases skip the iteration and finish on the accept edge.
  assign div_by_zero = op[2] && (operand_b == '0);
  assign div_ovf     = op[2] && !op[0] && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
  assign special     = div_by_zero || div_ovf;
  assign special_result = div_by_zero ? (op[1] ? operand_a : '1)
                                      : (op[1] ? '0 : operand_a);

  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
    div_trial = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, m_reg};
    if (op_reg[2]) begin
      // Remainder lives in hi, dividend shifts out of lo while quotient bits shift in.
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
    prod_fix = neg_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
    div_val  = op_reg[1] ? step_hi : step_lo;
    if (op_reg[2])
      final_result = neg_reg ? -div_val : div_val;
    else if (op_reg[1:0] == 2'b00)
      final_result = prod_fix[WIDTH-1:0];
    else
      final_result = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (accept)
          state_next = special ? DONE : CALC;
      end
      CALC: begin
        if (kill)
          state_next = IDLE;
        else if (last_step)
          state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (kill || result_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      m_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      op_reg  <= op;
      neg_reg <= (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
      cnt_reg <= '0;
      hi_reg  <= '0;
      if (op[2]) begin
        m_reg  <= mag_b;
        lo_reg <= mag_a;
      end else begin
        m_reg  <= mag_a;
        lo_reg <= mag_b;
      end
      if (special)
        result_reg <= special_result;
    end else if ((state_reg == CALC) && !kill) begin
      hi_reg  <= step_hi;
      lo_reg  <= step_lo;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last_step)
        result_reg <= final_result;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Bench for iter_muldiv_unit: directed ops checked every cycle against an
// arithmetic reference model, plus back-pressure, kill and reset scenarios.
module tb_iter_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         kill = 1'b0;
  logic         result_ready = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         start_ready, result_valid, busy;
  logic [W-1:0] result;

  iter_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
    .result_valid(result_valid), .result_ready(result_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int mode = 0;          // 0 unchecked, 1 op in flight, 2 must be idle
  int acc_cyc = 0;
  int exp_from = 0;
  logic [31:0] exp_result = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit products and native signed division.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pa, pb, p;
    int ia, ib;
    pa = (o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    pb = (o == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = pa * pb;
    ia = a;
    ib = b;
    case (o)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Every cycle: result_valid timing, result value/stability, handshake flags.
  always @(negedge clk) begin
    if (mode == 1) begin
      chk("valid_timing", 32'(result_valid), 32'(cyc >= exp_from));
      if (cyc >= acc_cyc) begin
        chk("busy_in_op", 32'(busy), 32'd1);
        chk("start_ready_in_op", 32'(start_ready), 32'd0);
      end
      if (result_valid) chk("result", result, exp_result);
    end else if (mode == 2) begin
      chk("idle_valid", 32'(result_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_start_ready", 32'(start_ready), 32'd1);
    end
  end

  // Special ops show result_valid in the first cycle after the accept edge,
  // normal ops W cycles later.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    acc_cyc    = cyc + 1;
    exp_from   = acc_cyc + (is_special(o, a, b) ? 0 : W);
    exp_result = model(o, a, b);
    mode       = 1;
    $display("[TB] op=%0d a=%h b=%h expect=%h", o, a, b, exp_result);
    @(posedge clk); #1;
    start_valid = 1'b0; op = ~o; operand_a = ~a; operand_b = ~b;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid actual=timeout required=result_valid within 100 cycles");
    end
  endtask

  task automatic finish_op();
    wait_valid();
    @(posedge clk); #1;
    mode = 0;
    chk("idle_after_handshake", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start_op(o, a, b);
    finish_op();
  endtask

  logic [2:0]  v_op [16] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd7, 3'd4, 3'd6, 3'd1, 3'd4, 3'd6, 3'd5};
  logic [31:0] v_a  [16] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
  logic [31:0] v_b  [16] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8765_4321, 32'hFFFF_FFF9, 32'd7, 32'd1};

  initial begin
    // Hand-computed values pin the reference model.
    chk("pin_mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh",   model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhu",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_divu",   model(3'd5, 32'd100, 32'd7), 32'd14);
    chk("pin_remu",   model(3'd7, 32'd100, 32'd7), 32'd2);
    chk("pin_div0",   model(3'd4, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin_remu0",  model(3'd7, 32'd5, 32'd0), 32'd5);
    chk("pin_ovf",    model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    @(negedge clk);
    chk("reset_start_ready", 32'(start_ready), 32'd1);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) run_op(v_op[i], v_a[i], v_b[i]);

    // Back-pressure: hold the result for 10 cycles, then release with a new start pending.
    result_ready = 1'b0;
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_valid();
    repeat (10) @(posedge clk);
    #1;
    result_ready = 1'b1;
    start_valid = 1'b1; op = 3'd5; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    chk("release_start_ready", 32'(start_ready), 32'd1);
    chk("release_valid", 32'(result_valid), 32'd0);
    acc_cyc    = cyc + 1;
    exp_from   = acc_cyc + W;
    exp_result = 32'd14;
    $display("[TB] op=5 a=00000064 b=00000007 expect=%h (queued behind back-pressure)", exp_result);
    @(posedge clk); #1;
    start_valid = 1'b0;
    finish_op();

    // Kill in the tenth CALC cycle.
    start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    mode = 2;
    $display("[TB] kill issued mid-calculation");
    repeat (40) @(posedge clk);
    #1 mode = 0;
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);

    // Kill in IDLE beats start_valid.
    @(posedge clk); #1;
    start_valid = 1'b1; kill = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd3;
    mode = 2;
    $display("[TB] start with kill in idle");
    @(posedge clk); #1;
    start_valid = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1 mode = 0;

    // Asynchronous reset in the middle of CALC.
    start_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(posedge clk);
    #1;
    mode = 0;
    reset = 1'b1;
    $display("[TB] reset mid-calculation");
    #1;
    chk("midreset_start_ready", 32'(start_ready), 32'd1);
    chk("midreset_valid", 32'(result_valid), 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_op(3'd7, 32'd100, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
